// File: rtl/ysyx_25040129_csr_file_pkg.sv
// ysyx_25040129_csr_file_pkg: CSR addresses, csr_op encodings, mstatus bit positions and the RW/RS/RC update helper.
package ysyx_25040129_csr_file_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    typedef enum logic [1:0] {
        CSR_NONE = 2'd0,
        CSR_RW   = 2'd1,
        CSR_RS   = 2'd2,
        CSR_RC   = 2'd3
    } csr_op_e;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Computed at 64 bits; callers truncate to their XLEN.
    function automatic logic [63:0] csr_apply(csr_op_e op, logic [63:0] old, logic [63:0] wd);
        return op == CSR_RW ? wd : op == CSR_RS ? (old | wd) : op == CSR_RC ? (old & ~wd) : old;
    endfunction

endpackage

// File: rtl/ysyx_25040129_csr_file_if.sv
// ysyx_25040129_csr_file_if: CSR access, trap and MRET signals between the pipeline (master) and the CSR file (slave).
//   master drives csr_addr/op/wen/wdata, trap_valid/cause/pc, mret
//   slave  drives csr_rdata, csr_illegal, trap_vector, mepc_out, mie_out
interface ysyx_25040129_csr_file_if #(parameter int XLEN = 32);
    logic [11:0]     csr_addr;
    logic [1:0]      csr_op;
    logic            csr_wen;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;
    logic            trap_valid;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_pc;
    logic            mret;
    logic [XLEN-1:0] trap_vector;
    logic [XLEN-1:0] mepc_out;
    logic            mie_out;

    modport master (
        output csr_addr, csr_op, csr_wen, csr_wdata, trap_valid, trap_cause, trap_pc, mret,
        input  csr_rdata, csr_illegal, trap_vector, mepc_out, mie_out
    );

    modport slave (
        input  csr_addr, csr_op, csr_wen, csr_wdata, trap_valid, trap_cause, trap_pc, mret,
        output csr_rdata, csr_illegal, trap_vector, mepc_out, mie_out
    );
endinterface

// File: rtl/ysyx_25040129_csr_counter.sv
// ysyx_25040129_csr_counter: free-running 64-bit cycle counter with independent low/high write ports.
//   i_wen_lo/i_wdata_lo overwrite bits [31:0], i_wen_hi/i_wdata_hi overwrite bits [63:32], o_cnt is the current value.
module ysyx_25040129_csr_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_wen_lo,
    input  logic        i_wen_hi,
    input  logic [31:0] i_wdata_lo,
    input  logic [31:0] i_wdata_hi,
    output logic [63:0] o_cnt
);
    logic [63:0] r_cnt;
    logic [63:0] w_inc;

    assign w_inc = r_cnt + 64'd1;
    assign o_cnt = r_cnt;

    // A written low half must not carry into the high half, so the high half holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt[31:0]  <= i_wen_lo ? i_wdata_lo : w_inc[31:0];
            r_cnt[63:32] <= i_wen_hi ? i_wdata_hi : i_wen_lo ? r_cnt[63:32] : w_inc[63:32];
        end
    end
endmodule

// File: rtl/ysyx_25040129_csr_file.sv
// ysyx_25040129_csr_file: machine-mode CSR file with trap entry, MRET and a 64-bit mcycle counter.
//   clk, rst_n (async active-low); bus (slave modport) carries CSR access, trap and MRET signals
//   and returns csr_rdata, csr_illegal, trap_vector, mepc_out, mie_out.
module ysyx_25040129_csr_file
    import ysyx_25040129_csr_file_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] HARTID   = '0,
    parameter logic [XLEN-1:0] VENDORID = XLEN'(32'h79737978),
    parameter logic [XLEN-1:0] ARCHID   = XLEN'(25040129)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    ysyx_25040129_csr_file_if.slave   bus
);
    logic            r_mie, r_mpie;
    logic [XLEN-1:0] r_mtvec, r_mscratch, r_mepc, r_mcause;
    logic [XLEN-1:0] w_mstatus, w_old, w_new, w_base;
    logic [63:0]     w_cnt, w_new64;
    logic            w_impl, w_ro, w_access, w_illegal, w_we;
    csr_op_e         w_op;

    assign w_op = csr_op_e'(bus.csr_op);

    always_comb begin
        w_mstatus = '0;
        w_mstatus[MSTATUS_MIE] = r_mie;
        w_mstatus[MSTATUS_MPIE] = r_mpie;
        w_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    always_comb begin
        w_impl = 1'b1;
        w_old = '0;
        case (bus.csr_addr)
            CSR_MSTATUS:   w_old = w_mstatus;
            CSR_MTVEC:     w_old = r_mtvec;
            CSR_MSCRATCH:  w_old = r_mscratch;
            CSR_MEPC:      w_old = r_mepc;
            CSR_MCAUSE:    w_old = r_mcause;
            CSR_MCYCLE:    w_old = XLEN'(w_cnt);
            CSR_MCYCLEH: begin
                w_impl = XLEN == 32;
                w_old = w_impl ? XLEN'(w_cnt[63:32]) : '0;
            end
            CSR_MVENDORID: w_old = VENDORID;
            CSR_MARCHID:   w_old = ARCHID;
            CSR_MHARTID:   w_old = HARTID;
            default:       w_impl = 1'b0;
        endcase
    end

    // Address space 0xC00-0xFFF is read-only.
    assign w_ro      = bus.csr_addr[11:10] == 2'b11;
    assign w_access  = w_op != CSR_NONE;
    assign w_illegal = w_access && (!w_impl || (w_ro && bus.csr_wen));
    assign w_we      = w_access && bus.csr_wen && !w_illegal && !bus.trap_valid && !bus.mret;
    assign w_new     = XLEN'(csr_apply(w_op, 64'(w_old), 64'(bus.csr_wdata)));
    assign w_new64   = 64'(w_new);

    ysyx_25040129_csr_counter u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wen_lo   (w_we && bus.csr_addr == CSR_MCYCLE),
        .i_wen_hi   (w_we && (XLEN == 32 ? bus.csr_addr == CSR_MCYCLEH : bus.csr_addr == CSR_MCYCLE)),
        .i_wdata_lo (w_new64[31:0]),
        .i_wdata_hi (XLEN == 32 ? w_new64[31:0] : w_new64[63:32]),
        .o_cnt      (w_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mtvec    <= '0;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
        end else if (bus.trap_valid) begin
            r_mepc   <= {bus.trap_pc[XLEN-1:2], 2'b00};
            r_mcause <= bus.trap_cause;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
        end else if (bus.mret) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
        end else if (w_we) begin
            if (bus.csr_addr == CSR_MSTATUS) begin
                r_mie  <= w_new[MSTATUS_MIE];
                r_mpie <= w_new[MSTATUS_MPIE];
            end
            // Only MODE 0 and 1 are kept; 2 and 3 collapse to direct mode.
            if (bus.csr_addr == CSR_MTVEC) r_mtvec <= {w_new[XLEN-1:2], 1'b0, w_new[1:0] == 2'b01};
            if (bus.csr_addr == CSR_MSCRATCH) r_mscratch <= w_new;
            if (bus.csr_addr == CSR_MEPC) r_mepc <= {w_new[XLEN-1:2], 2'b00};
            if (bus.csr_addr == CSR_MCAUSE) r_mcause <= w_new;
        end
    end

    assign w_base          = {r_mtvec[XLEN-1:2], 2'b00};
    assign bus.csr_rdata   = w_old;
    assign bus.csr_illegal = w_illegal;
    assign bus.trap_vector = r_mtvec[0] && bus.trap_cause[XLEN-1] ? w_base + {bus.trap_cause[XLEN-3:0], 2'b00} : w_base;
    assign bus.mepc_out    = r_mepc;
    assign bus.mie_out     = r_mie;
endmodule

// File: doc/ysyx_25040129_csr_file.md
YSYX_25040129_CSR_FILE -- requirements
Module: ysyx_25040129_csr_file

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- XLEN, 32, data width of every CSR port (32 or 64).
- HARTID, 0, constant read from mhartid.
- VENDORID, 32'h79737978, constant read from mvendorid.
- ARCHID, 25040129, constant read from marchid.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
- clk, in, 1, single clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous, active-low reset.
- csr_addr, in, 12, CSR address for both read and write.
- csr_op, in, 2, 0 NONE, 1 RW, 2 RS (set), 3 RC (clear).
- csr_wen, in, 1, write intent; the decoder deasserts it for RS/RC with a zero source.
- csr_wdata, in, XLEN, source operand.
- csr_rdata, out, XLEN, old value of csr_addr (combinational).
- csr_illegal, out, 1, access to an unimplemented address, or a write to a read-only CSR.
- trap_valid, in, 1, take trap this cycle.
- trap_cause, in, XLEN, cause; MSB=1 marks an interrupt.
- trap_pc, in, XLEN, PC of the trapping instruction.
- mret, in, 1, execute MRET this cycle.
- trap_vector, out, XLEN, redirect target on trap (combinational from trap_cause and mtvec).
- mepc_out, out, XLEN, current mepc for the MRET redirect.
- mie_out, out, 1, current mstatus.MIE.

Function
REQ-003 SHALL implement these CSRs: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, mvendorid 0xF11, marchid 0xF12, mhartid 0xF14. When XLEN=32 it SHALL also implement mcycleh 0xB80.
REQ-004 csr_rdata SHALL be valid in the same cycle. Any other address SHALL read 0 and assert csr_illegal whenever csr_op!=NONE.
REQ-005 The new value SHALL be computed as follows: RW gives wdata; RS gives old|wdata; RC gives old&~wdata. It SHALL be committed at the next edge only if csr_op!=NONE, csr_wen=1 and csr_illegal=0.
REQ-006 A write to 0xF11/0xF12/0xF14 with csr_wen=1 SHALL assert csr_illegal and change no state. A read with csr_wen=0 SHALL be legal.
REQ-007 mstatus SHALL implement only MIE[3] and MPIE[7]. MPP[12:11] SHALL read 2'b11. All other bits SHALL read 0 and ignore writes.
REQ-008 mtvec is WARL. MODE[1:0] values 2 and 3 SHALL be stored as 0. BASE[XLEN-1:2] SHALL be stored as written.
REQ-009 mepc[1:0] SHALL always read 0. mscratch and mcause SHALL be fully writable.
REQ-010 mcycle SHALL be a 64-bit counter that increments every cycle and wraps from all-ones to 0. With XLEN=32, 0xB00 SHALL access bits [31:0] and 0xB80 bits [63:32].
REQ-011 A CSR write to mcycle or mcycleh SHALL take precedence over the increment in that cycle. The unwritten half SHALL still increment normally, with carry suppressed across the written half.
REQ-012 On trap_valid, at the next edge: mepc<=trap_pc with [1:0]=0; mcause<=trap_cause; MPIE<=MIE; MIE<=0.
REQ-013 On mret, at the next edge: MIE<=MPIE; MPIE<=1.
REQ-014 trap_vector SHALL equal BASE when MODE=0 or trap_cause MSB=0. Otherwise it SHALL equal BASE + 4*trap_cause[XLEN-2:0], truncated to XLEN.
REQ-015 Priority within one cycle SHALL be trap_valid > mret > CSR write. The lower-priority action SHALL be dropped entirely; mcycle still increments.
REQ-016 Simultaneous trap_valid and mret SHALL behave as trap only.
REQ-017 An illegal access SHALL have no side effects beyond asserting csr_illegal.

Reset
REQ-018 While rst_n=0, asynchronously: mstatus, mtvec, mscratch, mepc, mcause and mcycle SHALL be 0. Consequently mie_out=0, mepc_out=0 and trap_vector=0.
REQ-019 Deassertion of rst_n mid-operation SHALL drop any pending write. mcycle SHALL read 0 in the first cycle after release and 1 in the second.

Structure
REQ-020 CSR address constants, csr_op encodings and mstatus bit positions SHALL reside in the shared ysyx_25040129 define/package file.
REQ-021 The 64-bit counter SHALL be a sub-module, ysyx_25040129_csr_counter, with a split low/high write port. Everything else SHALL remain in this module.

Verification
REQ-022 Reset, then RW 0x305 with 0x80000003 -> read returns 0x80000000 (MODE coerced to 0); csr_illegal=0.
REQ-023 mstatus=0x8 (MIE=1); trap_valid, cause=11, pc=0x80000104 -> next cycle mepc=0x80000104, mcause=11, mstatus reads 0x1880; then mret -> mstatus reads 0x1888.
REQ-024 mtvec=0x80001001; trap_cause=0x80000007 -> trap_vector=0x8000101C. With trap_cause=2 -> trap_vector=0x80001000.
REQ-025 RW mcycle 0xFFFFFFFF and mcycleh 0xFFFFFFFF (XLEN=32) -> two cycles later mcycle reads 0x00000000 and mcycleh reads 0x00000000 (wrap); then RS 0x340 with 0xF0 on mscratch=0x0F -> reads 0xFF, then RC 0x0F -> reads 0xF0.
REQ-026 Same cycle: trap_valid with csr RW 0x341=0x1234 -> mepc=trap_pc, and the CSR write is discarded. Write to 0xF11, and separately read of 0x7C0 -> csr_illegal=1, no state change, read value 0.
